cordic_vec_rtl: RTL

- Iterative fixed-point CORDIC in vectoring mode, the inverse of the team's sin/cos rotation core.
- Takes a Cartesian vector (x_in, y_in) in fixpoint(2:10) and returns its polar angle atan2(y, x) and its gain-compensated magnitude.
- Uses the same start/ready_out four-phase handshake as the rotation core, so both cores can share a controller.

---
 rtl/cordic_vec_rtl_if.sv | 22 ++
 rtl/cordic_vec_rtl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cordic_vec_rtl_if.sv
// Handshake and data bundle for the vectoring CORDIC core.
// The master drives start and the operands; the slave returns angle, magnitude and ready_out.
interface cordic_vec_rtl_if #(
    parameter int W = 12
);
    logic                start;
    logic signed [W-1:0] x_in;
    logic signed [W-1:0] y_in;
    logic                ready_out;
    logic signed [W:0]   angle_out;
    logic        [W:0]   mag_out;

    modport master (
        output start, x_in, y_in,
        input  ready_out, angle_out, mag_out
    );

    modport slave (
        input  start, x_in, y_in,
        output ready_out, angle_out, mag_out
    );
endinterface

// File: rtl/cordic_vec_rtl.sv
// Iterative vectoring-mode CORDIC: atan2(y, x) and gain-compensated magnitude in fixpoint.
// Define CORDIC_VEC_ROUND_EN to round the magnitude to nearest instead of truncating it.
module cordic_vec_rtl #(
    parameter int W         = 12,
    parameter int FXP_SHIFT = 10,
    parameter int ITER      = 11
) (
    input logic            clock,
    input logic            reset,
    cordic_vec_rtl_if.slave bus
);

    localparam int XW   = W + 2;
    localparam int ZW   = W + 1;
    localparam int ACCW = 24;

    localparam logic [3:0]           LAST_ITER  = 4'(ITER - 1);
    localparam logic [3:0]           LAST_SCALE = 4'd2;
    localparam logic signed [ZW-1:0] HALF_PI    = ZW'(1608);

`ifdef CORDIC_VEC_ROUND_EN
    localparam logic signed [ACCW-1:0] ROUND_BIAS = ACCW'(1 << (FXP_SHIFT - 1));
`else
    localparam logic signed [ACCW-1:0] ROUND_BIAS = '0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        ITERATE,
        SCALE,
        OUT,
        HOLD
    } state_t;

    state_t                 state_q,    state_d;
    logic signed [XW-1:0]   x_q,        x_d;
    logic signed [XW-1:0]   y_q,        y_d;
    logic signed [ZW-1:0]   z_q,        z_d;
    logic        [3:0]      cnt_q,      cnt_d;
    logic signed [ACCW-1:0] acc_q,      acc_d;
    logic                   zeroFlag_q, zeroFlag_d;
    logic                   ready_q,    ready_d;
    logic signed [ZW-1:0]   angle_q,    angle_d;
    logic        [ZW-1:0]   mag_q,      mag_d;

    logic signed [XW-1:0]   xShift;
    logic signed [XW-1:0]   yShift;
    logic signed [ACCW-1:0] xExt;

    function automatic logic signed [ZW-1:0] atanLut(input logic [3:0] idx);
        logic signed [ZW-1:0] val;
        case (idx)
            4'd0:    val = ZW'(804);
            4'd1:    val = ZW'(475);
            4'd2:    val = ZW'(251);
            4'd3:    val = ZW'(127);
            4'd4:    val = ZW'(64);
            4'd5:    val = ZW'(32);
            4'd6:    val = ZW'(16);
            4'd7:    val = ZW'(8);
            4'd8:    val = ZW'(4);
            4'd9:    val = ZW'(2);
            4'd10:   val = ZW'(1);
            default: val = '0;
        endcase
        return val;
    endfunction

    assign xShift = x_q >>> cnt_q;
    assign yShift = y_q >>> cnt_q;
    assign xExt   = $signed({{(ACCW - XW){x_q[XW-1]}}, x_q});

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            z_q        <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            zeroFlag_q <= 1'b0;
            ready_q    <= 1'b0;
            angle_q    <= '0;
            mag_q      <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            z_q        <= z_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            zeroFlag_q <= zeroFlag_d;
            ready_q    <= ready_d;
            angle_q    <= angle_d;
            mag_q      <= mag_d;
        end
    end

    // Only IDLE and HOLD look at start, so pulses while busy have no effect.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        z_d        = z_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        zeroFlag_d = zeroFlag_q;
        ready_d    = ready_q;
        angle_d    = angle_q;
        mag_d      = mag_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    x_d        = {{(XW - W){bus.x_in[W-1]}}, bus.x_in};
                    y_d        = {{(XW - W){bus.y_in[W-1]}}, bus.y_in};
                    zeroFlag_d = (bus.x_in == '0) && (bus.y_in == '0);
                    ready_d    = 1'b0;
                    state_d    = PRE;
                end
            end

            // Fold left-half-plane vectors by +/-90 degrees so the iterations converge.
            PRE: begin
                if (!x_q[XW-1]) begin
                    z_d = '0;
                end else if (!y_q[XW-1]) begin
                    x_d = y_q;
                    y_d = -x_q;
                    z_d = HALF_PI;
                end else begin
                    x_d = -y_q;
                    y_d = x_q;
                    z_d = -HALF_PI;
                end
                cnt_d   = '0;
                state_d = ITERATE;
            end

            ITERATE: begin
                if (!y_q[XW-1]) begin
                    x_d = x_q + yShift;
                    y_d = y_q - xShift;
                    z_d = z_q + atanLut(cnt_q);
                end else begin
                    x_d = x_q - yShift;
                    y_d = y_q + xShift;
                    z_d = z_q - atanLut(cnt_q);
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_ITER) begin
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = SCALE;
                end
            end

            // K = 622/1024 built from 512+64+32+8+4+2, two terms per cycle.
            SCALE: begin
                case (cnt_q[1:0])
                    2'd0:    acc_d = (xExt <<< 9) + (xExt <<< 6);
                    2'd1:    acc_d = acc_q + (xExt <<< 5) + (xExt <<< 3);
                    default: acc_d = acc_q + (xExt <<< 2) + (xExt <<< 1);
                endcase
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_SCALE) begin
                    cnt_d   = '0;
                    state_d = OUT;
                end
            end

            OUT: begin
                if (zeroFlag_q) begin
                    angle_d = '0;
                    mag_d   = '0;
                end else begin
                    angle_d = z_q;
                    mag_d   = ZW'((acc_q + ROUND_BIAS) >>> FXP_SHIFT);
                end
                ready_d = 1'b1;
                state_d = HOLD;
            end

            HOLD: begin
                if (!bus.start) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ready_out = ready_q;
    assign bus.angle_out = angle_q;
    assign bus.mag_out   = mag_q;

endmodule
